// File: rtl/fpu_job_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// fpu_job_scheduler_pkg
// Shared FPU defines used by the job scheduler and its pending-job queue.
//   op_id     : operation codes a requester can hand to the FPU job manager
//   job_t     : one queued job, {requester id, operation}
//   defaults  : requester count and queue depth used when a parent does not
//               override them
//   isSupported() : which operations the job manager can actually execute
// ----------------------------------------------------------------------------
package fpu_job_scheduler_pkg;

    localparam int DEFAULT_NUM_REQ    = 4;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Job ids are sized for the default requester count. A parent that needs
    // more requesters raises DEFAULT_NUM_REQ so every job_t widens with it.
    localparam int JOB_ID_W = $clog2(DEFAULT_NUM_REQ);

    typedef enum logic [2:0] {
        OP_NOP     = 3'd0,
        LINEAR_FW  = 3'd1,
        LINEAR_BW  = 3'd2,
        FLATTEN_FW = 3'd3,
        FLATTEN_BW = 3'd4,
        CONV_FW    = 3'd5,
        CONV_BW    = 3'd6,
        OP_RSVD    = 3'd7
    } op_id;

    typedef struct packed {
        logic [JOB_ID_W-1:0] id;
        op_id                op;
    } job_t;

    // Only these two operations are wired up in the job manager; anything
    // else is bounced back to the requester as an error completion.
    function automatic logic isSupported(input op_id op);
        return (op == LINEAR_FW) || (op == FLATTEN_BW);
    endfunction

endpackage

// File: rtl/fpu_job_fifo.sv
// ----------------------------------------------------------------------------
// fpu_job_fifo
// Pending-job queue between the requester arbiter and the dispatch FSM.
//   clk, rst_l   : clock, asynchronous active-low reset (empties the queue)
//   push_i       : write pushData_i at the tail (ignored when full)
//   pushData_i   : job to enqueue
//   pop_i        : drop the head entry (ignored when empty)
//   popData_o    : current head entry, valid while empty_o is low
//   full_o       : DEPTH entries held
//   empty_o      : no entries held
//   count_o      : number of entries held, 0..DEPTH
// DEPTH must be a power of two (at least 2) so the pointers wrap for free.
// ----------------------------------------------------------------------------
module fpu_job_fifo
    import fpu_job_scheduler_pkg::*;
#(
    parameter int DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst_l,
    input  logic                   push_i,
    input  job_t                   pushData_i,
    input  logic                   pop_i,
    output job_t                   popData_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_COUNT = (AW + 1)'(DEPTH);

    job_t          mem_q [DEPTH];
    logic [AW-1:0] wrPtr_q;
    logic [AW-1:0] rdPtr_q;
    logic [AW:0]   count_q;
    logic          doPush;
    logic          doPop;

    assign full_o    = (count_q == FULL_COUNT);
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign popData_o = mem_q[rdPtr_q];
    assign doPush    = push_i && !full_o;
    assign doPop     = pop_i && !empty_o;

    // Pointer and occupancy bookkeeping. The pointers are exactly AW bits, so
    // incrementing past DEPTH-1 rolls back to 0; a simultaneous push and pop
    // moves both pointers and leaves the count where it was.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + AW'(1);
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + AW'(1);
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage needs no reset: an entry is only ever read after it has
    // been written, because empty_o guards every pop.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem_q[wrPtr_q] <= pushData_i;
        end
    end

endmodule

// File: rtl/fpu_job_scheduler.sv
// ----------------------------------------------------------------------------
// fpu_job_scheduler
// Collects FPU jobs from NUM_REQ requesters with a round-robin arbiter,
// queues them, and hands them one at a time to the FPU job manager.
//   clk, rst_l  : clock, asynchronous active-low reset
//   req_valid   : per-requester request, held until the matching req_ready
//   req_op      : per-requester operation
//   req_ready   : one-hot (or zero) combinational accept strobe
//   jm_avail    : a job is being offered to the job manager
//   jm_op       : operation of the offered job
//   jm_done     : job manager finished the offered job
//   cmpl_valid  : one-cycle completion pulse
//   cmpl_id     : requester the completion belongs to
//   cmpl_err    : completion is for an unsupported op that was never issued
//   q_count     : jobs waiting in the queue
//   busy        : work is queued or the dispatch side is not idle
// ----------------------------------------------------------------------------
module fpu_job_scheduler
    import fpu_job_scheduler_pkg::*;
#(
    parameter int NUM_REQ    = DEFAULT_NUM_REQ,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_l,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  op_id                         req_op [NUM_REQ],
    output logic [NUM_REQ-1:0]           req_ready,
    output logic                         jm_avail,
    output op_id                         jm_op,
    input  logic                         jm_done,
    output logic                         cmpl_valid,
    output logic [$clog2(NUM_REQ)-1:0]   cmpl_id,
    output logic                         cmpl_err,
    output logic [$clog2(FIFO_DEPTH):0]  q_count,
    output logic                         busy
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    logic [IDW-1:0] rrPtr_q, rrPtr_d;
    logic [IDW-1:0] grantIdx;
    logic [IDW-1:0] cand;
    logic [IDW:0]   candSum;
    logic           grantAny;
    logic           accept;

    logic           fifoFull;
    logic           fifoEmpty;
    logic           fifoPop;
    job_t           fifoHead;
    job_t           pushJob;

    logic [1:0]     state_q, state_d;
    job_t           job_q, job_d;
    logic           jobStaged_q, jobStaged_d;
    logic           cmplValid_q, cmplValid_d;
    logic           cmplErr_q, cmplErr_d;
    logic [IDW-1:0] cmplId_q, cmplId_d;

    // Round-robin search: walk the requesters starting at rrPtr_q (the one
    // after the last winner) and take the first that is asking. The index is
    // wrapped by hand so NUM_REQ need not be a power of two.
    always_comb begin
        grantAny = 1'b0;
        grantIdx = '0;
        candSum  = '0;
        cand     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            candSum = {1'b0, rrPtr_q} + (IDW + 1)'(i);
            if (candSum >= (IDW + 1)'(NUM_REQ)) begin
                candSum = candSum - (IDW + 1)'(NUM_REQ);
            end
            cand = candSum[IDW-1:0];
            if (!grantAny && req_valid[cand]) begin
                grantAny = 1'b1;
                grantIdx = cand;
            end
        end
    end

    // A full queue refuses everyone, even if the FSM frees a slot this very
    // cycle, so req_ready never depends on the dispatch side.
    assign accept = grantAny && !fifoFull;

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    // The pointer only moves on an actual accept; a refused winner keeps its
    // priority for the next cycle.
    always_comb begin
        rrPtr_d = rrPtr_q;
        if (accept) begin
            rrPtr_d = (grantIdx == IDW'(NUM_REQ - 1)) ? '0 : grantIdx + IDW'(1);
        end
    end

    assign pushJob.id = JOB_ID_W'(grantIdx);
    assign pushJob.op = req_op[grantIdx];

    fpu_job_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_l      (rst_l),
        .push_i     (accept),
        .pushData_i (pushJob),
        .pop_i      (fifoPop),
        .popData_o  (fifoHead),
        .full_o     (fifoFull),
        .empty_o    (fifoEmpty),
        .count_o    (q_count)
    );

    // Dispatch FSM. IDLE works in two steps: first the head is popped into
    // job_q (jobStaged_q marks it), then the staged op is inspected on the
    // next cycle and either issued or bounced as an error completion. The
    // extra staging cycle keeps the op decode off the queue read path.
    // Completions are registered, so they appear the cycle after the
    // decision: for a normal job that is the first RELEASE cycle.
    always_comb begin
        state_d     = state_q;
        job_d       = job_q;
        jobStaged_d = jobStaged_q;
        cmplValid_d = 1'b0;
        cmplErr_d   = 1'b0;
        cmplId_d    = cmplId_q;
        fifoPop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (jobStaged_q) begin
                    jobStaged_d = 1'b0;
                    if (isSupported(job_q.op)) begin
                        state_d = ST_ISSUE;
                    end else begin
                        cmplValid_d = 1'b1;
                        cmplErr_d   = 1'b1;
                        cmplId_d    = IDW'(job_q.id);
                    end
                end else if (!fifoEmpty) begin
                    fifoPop     = 1'b1;
                    job_d       = fifoHead;
                    jobStaged_d = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (jm_done) begin
                    state_d     = ST_RELEASE;
                    cmplValid_d = 1'b1;
                    cmplId_d    = IDW'(job_q.id);
                end
            end
            ST_RELEASE: begin
                if (!jm_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // All scheduler state. Reset drops whatever job is in flight without a
    // completion; the queue contents are cleared by the FIFO's own reset.
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            rrPtr_q     <= '0;
            state_q     <= ST_IDLE;
            job_q       <= '0;
            jobStaged_q <= 1'b0;
            cmplValid_q <= 1'b0;
            cmplErr_q   <= 1'b0;
            cmplId_q    <= '0;
        end else begin
            rrPtr_q     <= rrPtr_d;
            state_q     <= state_d;
            job_q       <= job_d;
            jobStaged_q <= jobStaged_d;
            cmplValid_q <= cmplValid_d;
            cmplErr_q   <= cmplErr_d;
            cmplId_q    <= cmplId_d;
        end
    end

    // A staged job counts as pending work even though the FSM is still IDLE.
    assign jm_avail   = (state_q == ST_ISSUE);
    assign jm_op      = job_q.op;
    assign cmpl_valid = cmplValid_q;
    assign cmpl_err   = cmplErr_q;
    assign cmpl_id    = cmplId_q;
    assign busy       = !fifoEmpty || (state_q != ST_IDLE) || jobStaged_q;

endmodule

// File: tb/tb_fpu_job_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fpu_job_scheduler
// Directed scenarios plus a randomized run of fpu_job_scheduler, every cycle
// compared against a job-level reference model (a queue of pending jobs and
// the lifecycle of the one job the scheduler is handling).
// ----------------------------------------------------------------------------
module tb_fpu_job_scheduler;
    import fpu_job_scheduler_pkg::*;

    localparam int NR = 4;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst_l;
    logic [NR-1:0] req_valid;
    op_id          req_op [NR];
    logic [NR-1:0] req_ready;
    logic          jm_avail;
    op_id          jm_op;
    logic          jm_done;
    logic          cmpl_valid;
    logic [1:0]    cmpl_id;
    logic          cmpl_err;
    logic [2:0]    q_count;
    logic          busy;

    always #5 clk = ~clk;

    fpu_job_scheduler #(
        .NUM_REQ    (NR),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk        (clk),
        .rst_l      (rst_l),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_ready  (req_ready),
        .jm_avail   (jm_avail),
        .jm_op      (jm_op),
        .jm_done    (jm_done),
        .cmpl_valid (cmpl_valid),
        .cmpl_id    (cmpl_id),
        .cmpl_err   (cmpl_err),
        .q_count    (q_count),
        .busy       (busy)
    );

    int errors = 0;
    int checks = 0;

    // Requester side: each requester holds its request until it is granted.
    bit   reqHold [NR];
    op_id reqOp   [NR];

    // Reference model: pending jobs, the job taken from the queue, and where
    // that job is in its life (just taken, offered to the manager, or waiting
    // for the manager to drop done), plus the completion due this cycle.
    typedef struct {
        int   id;
        op_id op;
    } mjob_t;

    mjob_t pendQ[$];
    mjob_t mJob;
    int    mRr;
    bit    mTaken;
    bit    mOffered;
    bit    mWaitDrop;
    bit    mCmpl;
    int    mCmplId;
    bit    mCmplErr;

    // What the DUT showed in the most recent applyStimulus call.
    logic [NR-1:0] obsReady;
    logic          obsAvail;
    logic          obsCmpl;
    logic [1:0]    obsCmplId;
    logic          obsCmplErr;
    int            obsCycle;
    int            cycle = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        pendQ.delete();
        mRr       = 0;
        mTaken    = 0;
        mOffered  = 0;
        mWaitDrop = 0;
        mCmpl     = 0;
        mCmplId   = 0;
        mCmplErr  = 0;
    endtask

    // One clock cycle: drive at the falling edge, check 1 time unit later,
    // then advance the model across the coming rising edge.
    task automatic applyStimulus(input logic done);
        int    expGrant;
        bit    nCmpl;
        int    nId;
        bit    nErr;
        for (int i = 0; i < NR; i++) begin
            req_valid[i] = reqHold[i];
            req_op[i]    = reqOp[i];
        end
        jm_done = done;
        #1;
        expGrant = -1;
        if (pendQ.size() < FD) begin
            for (int k = 0; k < NR; k++) begin
                int c;
                c = (mRr + k) % NR;
                if (expGrant < 0 && reqHold[c]) expGrant = c;
            end
        end
        checkOutput("req_ready", req_ready, (expGrant >= 0) ? (32'd1 << expGrant) : 32'd0);
        checkOutput("jm_avail", jm_avail, mOffered);
        if (mOffered) checkOutput("jm_op", jm_op, mJob.op);
        checkOutput("cmpl_valid", cmpl_valid, mCmpl);
        if (mCmpl) begin
            checkOutput("cmpl_id", cmpl_id, mCmplId);
            checkOutput("cmpl_err", cmpl_err, mCmplErr);
        end
        checkOutput("q_count", q_count, pendQ.size());
        checkOutput("busy", busy, (pendQ.size() != 0) || mTaken || mOffered || mWaitDrop);
        obsReady   = req_ready;
        obsAvail   = jm_avail;
        obsCmpl    = cmpl_valid;
        obsCmplId  = cmpl_id;
        obsCmplErr = cmpl_err;
        obsCycle   = cycle;

        nCmpl = 0;
        nId   = mCmplId;
        nErr  = 0;
        if (mOffered) begin
            if (done) begin
                mOffered  = 0;
                mWaitDrop = 1;
                nCmpl     = 1;
                nId       = mJob.id;
            end
        end else if (mWaitDrop) begin
            if (!done) mWaitDrop = 0;
        end else if (mTaken) begin
            mTaken = 0;
            if (mJob.op == LINEAR_FW || mJob.op == FLATTEN_BW) begin
                mOffered = 1;
            end else begin
                nCmpl = 1;
                nErr  = 1;
                nId   = mJob.id;
            end
        end else if (pendQ.size() > 0) begin
            mJob   = pendQ.pop_front();
            mTaken = 1;
        end
        if (expGrant >= 0) begin
            pendQ.push_back('{expGrant, reqOp[expGrant]});
            mRr = (expGrant + 1) % NR;
            reqHold[expGrant] = 0;
        end
        mCmpl    = nCmpl;
        mCmplId  = nId;
        mCmplErr = nErr;
        cycle++;
        @(negedge clk);
    endtask

    // Asserts reset from a falling edge, checks the asynchronous clear and the
    // state after the next rising edge, then releases reset.
    task automatic doReset(input string tag);
        for (int i = 0; i < NR; i++) reqHold[i] = 0;
        req_valid = '0;
        jm_done   = 1'b0;
        rst_l     = 1'b0;
        #1;
        checkOutput({tag, "_jm_avail"}, jm_avail, 0);
        checkOutput({tag, "_jm_op"}, jm_op, 0);
        checkOutput({tag, "_q_count"}, q_count, 0);
        checkOutput({tag, "_busy"}, busy, 0);
        checkOutput({tag, "_cmpl_valid"}, cmpl_valid, 0);
        checkOutput({tag, "_cmpl_id"}, cmpl_id, 0);
        checkOutput({tag, "_cmpl_err"}, cmpl_err, 0);
        @(posedge clk);
        #1;
        checkOutput({tag, "_edge_jm_avail"}, jm_avail, 0);
        checkOutput({tag, "_edge_q_count"}, q_count, 0);
        checkOutput({tag, "_edge_busy"}, busy, 0);
        checkOutput({tag, "_edge_cmpl_valid"}, cmpl_valid, 0);
        @(negedge clk);
        rst_l = 1'b1;
        modelReset();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    int   acceptCyc, availCyc, availCount, cmplSeen, cmplIdSeen, cmplErrSeen;
    int   lowAfter, holdAvail, secondAvailCyc, releaseEndCyc;
    bit   doneGiven, seenAvail, firstDone, availEver;
    logic d;
    int   grants[$];

    initial begin
        rst_l     = 1'b0;
        req_valid = '0;
        jm_done   = 1'b0;
        for (int i = 0; i < NR; i++) begin
            reqHold[i] = 0;
            reqOp[i]   = OP_NOP;
            req_op[i]  = OP_NOP;
        end
        modelReset();
        @(negedge clk);
        $display("[TB] reset state");
        doReset("reset");

        // Single supported job from requester 2, done after 5 offered cycles.
        $display("[TB] single job");
        reqHold[2] = 1;
        reqOp[2]   = LINEAR_FW;
        acceptCyc = -1; availCyc = -1; availCount = 0; cmplSeen = 0;
        cmplIdSeen = 0; cmplErrSeen = 0; doneGiven = 0;
        for (int t = 0; t < 20; t++) begin
            d = (availCount >= 5) && !doneGiven;
            applyStimulus(d);
            if (d) doneGiven = 1;
            if (obsReady[2] && acceptCyc < 0) acceptCyc = obsCycle;
            if (obsAvail) begin
                if (availCyc < 0) availCyc = obsCycle;
                availCount++;
            end
            if (obsCmpl) begin
                cmplSeen++;
                cmplIdSeen  = obsCmplId;
                cmplErrSeen = obsCmplErr;
            end
        end
        // Accepting edge ends sample k; the offer appears after edge N+2,
        // i.e. in sample k+3.
        checkOutput("single_latency", availCyc - acceptCyc, 3);
        checkOutput("single_avail_cycles", availCount, 6);
        checkOutput("single_cmpl_count", cmplSeen, 1);
        checkOutput("single_cmpl_id", cmplIdSeen, 2);
        checkOutput("single_cmpl_err", cmplErrSeen, 0);
        checkOutput("single_final_avail", obsAvail, 0);

        // Unsupported op from requester 1 is bounced with an error completion.
        $display("[TB] unsupported op");
        reqHold[1] = 1;
        reqOp[1]   = LINEAR_BW;
        cmplSeen = 0; availEver = 0;
        for (int t = 0; t < 10; t++) begin
            applyStimulus(1'b0);
            if (obsAvail) availEver = 1;
            if (obsCmpl) begin
                cmplSeen++;
                cmplIdSeen  = obsCmplId;
                cmplErrSeen = obsCmplErr;
            end
        end
        checkOutput("unsup_cmpl_count", cmplSeen, 1);
        checkOutput("unsup_cmpl_id", cmplIdSeen, 1);
        checkOutput("unsup_cmpl_err", cmplErrSeen, 1);
        checkOutput("unsup_never_avail", availEver, 0);

        // jm_done while idle is ignored, then a slow release with a second
        // job waiting behind it.
        $display("[TB] idle done and slow release");
        for (int t = 0; t < 3; t++) applyStimulus(1'b1);
        reqHold[0] = 1; reqOp[0] = LINEAR_FW;
        reqHold[3] = 1; reqOp[3] = FLATTEN_BW;
        seenAvail = 0; firstDone = 0; lowAfter = 0; holdAvail = 0;
        secondAvailCyc = -1; releaseEndCyc = -1;
        for (int t = 0; t < 30; t++) begin
            d = seenAvail && !firstDone && (lowAfter < 4);
            if (seenAvail && !firstDone && !d && releaseEndCyc < 0) releaseEndCyc = cycle;
            applyStimulus(d);
            if (!seenAvail && obsAvail) begin
                seenAvail = 1;
            end else if (seenAvail && !firstDone && !obsAvail && lowAfter < 4) begin
                lowAfter++;
            end else if (seenAvail && !firstDone && obsAvail && lowAfter > 0) begin
                holdAvail++;
            end
            if (releaseEndCyc >= 0) firstDone = 1;
            if (firstDone && obsAvail && secondAvailCyc < 0) secondAvailCyc = obsCycle;
        end
        checkOutput("slow_avail_while_done_held", holdAvail, 0);
        checkOutput("slow_second_after_release", (secondAvailCyc > releaseEndCyc) ? 1 : 0, 1);

        // Fairness and full queue: everyone asks every cycle, manager never
        // finishes.
        $display("[TB] fairness and full queue");
        doReset("rst_fair");
        grants.delete();
        for (int t = 0; t < 10; t++) begin
            for (int i = 0; i < NR; i++) begin
                reqHold[i] = 1;
                reqOp[i]   = LINEAR_FW;
            end
            applyStimulus(1'b0);
            for (int i = 0; i < NR; i++) if (obsReady[i]) grants.push_back(i);
        end
        checkOutput("fair_grant_count", grants.size(), 5);
        for (int g = 0; g < 5 && g < grants.size(); g++) begin
            checkOutput($sformatf("fair_grant_%0d", g), grants[g], g % NR);
        end
        checkOutput("full_q_count", q_count, FD);
        checkOutput("full_ready", obsReady, 0);
        checkOutput("rst_mid_pre_avail", jm_avail, 1);

        // Reset while a job is offered and the queue is full.
        $display("[TB] reset mid-issue");
        doReset("rst_mid");
        for (int t = 0; t < 3; t++) applyStimulus(1'b0);

        // Randomized traffic with one reset in the middle.
        $display("[TB] random traffic");
        for (int t = 0; t < 600; t++) begin
            for (int i = 0; i < NR; i++) begin
                if (!reqHold[i] && $urandom_range(0, 3) == 0) begin
                    reqHold[i] = 1;
                    reqOp[i]   = op_id'($urandom_range(0, 7));
                end
            end
            applyStimulus($urandom_range(0, 2) == 0);
            if (t == 300) doReset("rst_rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
